// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// Multi-cycle ALU execution unit. A command (alu_cnt, a, b) is captured when
// start is seen in IDLE. Logic and add/sub operations finish in one cycle.
// Shifts move one bit per cycle, and multiply runs a WIDTH-step shift-add
// loop. The result and flags are registered when the FSM enters DONE and
// stay stable until the next DONE entry.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   command strobe, only looked at in IDLE
//   alu_cnt    in   [3:0] operation code
//   a, b       in   [WIDTH-1:0] operands (shift amount is b[3:0])
//   busy       out  high in SHIFT, MULT and DONE
//   done       out  one-cycle pulse while in DONE
//   result     out  [WIDTH-1:0] result, or low half of the product
//   result_hi  out  [WIDTH-1:0] high half of the product, 0 otherwise
//   zero       out  result (full product for mult) is zero
//   carry      out  add carry-out / sub borrow
//   ovf        out  signed overflow for add/sub
//   illegal    out  opcode was not a decoded operation
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_cnt,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             illegal
);

    localparam int MSB = WIDTH - 1;
    // The counter must hold both WIDTH (multiply) and 15 (largest shift).
    localparam int CW  = ($clog2(WIDTH + 1) > 4) ? $clog2(WIDTH + 1) : 4;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b1100;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_MULT = 4'b0111;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_MULT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q,     state_d;
    logic [3:0]       op_q,        op_d;
    logic [WIDTH-1:0] mcand_q,     mcand_d;
    logic [WIDTH-1:0] hi_q,        hi_d;
    logic [WIDTH-1:0] lo_q,        lo_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             zero_q,      zero_d;
    logic             carry_q,     carry_d;
    logic             ovf_q,       ovf_d;
    logic             illegal_q,   illegal_d;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   step_sum;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    logic             load_out;
    logic [WIDTH-1:0] out_res;
    logic [WIDTH-1:0] out_hi;
    logic             out_carry;
    logic             out_ovf;
    logic             out_illegal;

    // Datapath helpers. Bit WIDTH of diff_w is the unsigned borrow (a < b).
    // One multiply step adds the multiplicand into the high half when the
    // multiplier LSB is set, then shifts the {hi, lo} pair right by one.
    always_comb begin
        sum_w      = {1'b0, a} + {1'b0, b};
        diff_w     = {1'b0, a} - {1'b0, b};
        shift_next = (op_q == OP_SRL) ? (lo_q >> 1) : (lo_q << 1);
        addend     = lo_q[0] ? mcand_q : '0;
        step_sum   = {1'b0, hi_q} + {1'b0, addend};
        step_hi    = step_sum[WIDTH:1];
        step_lo    = {step_sum[0], lo_q[WIDTH-1:1]};
    end

    // Next-state logic. Whenever a path enters DONE it raises load_out and
    // fills the out_* values. The output registers then update in one place,
    // so they only change on a DONE entry.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        mcand_d     = mcand_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        illegal_d   = illegal_q;
        load_out    = 1'b0;
        out_res     = '0;
        out_hi      = '0;
        out_carry   = 1'b0;
        out_ovf     = 1'b0;
        out_illegal = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d     = alu_cnt;
                    state_d  = S_DONE;
                    load_out = 1'b1;
                    case (alu_cnt)
                        OP_AND: out_res = a & b;
                        OP_OR:  out_res = a | b;
                        OP_XOR: out_res = a ^ b;
                        OP_ADD: begin
                            out_res   = sum_w[WIDTH-1:0];
                            out_carry = sum_w[WIDTH];
                            out_ovf   = (a[MSB] == b[MSB]) && (sum_w[MSB] != a[MSB]);
                        end
                        OP_SUB: begin
                            out_res   = diff_w[WIDTH-1:0];
                            out_carry = diff_w[WIDTH];
                            out_ovf   = (a[MSB] != b[MSB]) && (diff_w[MSB] != a[MSB]);
                        end
                        OP_SLL, OP_SRL: begin
                            if (b[3:0] == 4'd0) begin
                                out_res = a;
                            end else begin
                                load_out = 1'b0;
                                state_d  = S_SHIFT;
                                lo_d     = a;
                                cnt_d    = CW'(b[3:0]);
                            end
                        end
                        OP_MULT: begin
                            load_out = 1'b0;
                            state_d  = S_MULT;
                            mcand_d  = a;
                            lo_d     = b;
                            hi_d     = '0;
                            cnt_d    = CW'(WIDTH);
                        end
                        default: out_illegal = 1'b1;
                    endcase
                end
            end
            S_SHIFT: begin
                // The last shift goes straight into the result register.
                lo_d  = shift_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    out_res  = shift_next;
                    load_out = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_MULT: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    out_res  = step_lo;
                    out_hi   = step_hi;
                    load_out = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load_out) begin
            result_d    = out_res;
            result_hi_d = out_hi;
            zero_d      = (out_res == '0) && (out_hi == '0);
            carry_d     = out_carry;
            ovf_d       = out_ovf;
            illegal_d   = out_illegal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            mcand_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            mcand_q     <= mcand_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            illegal_q   <= illegal_d;
        end
    end

    // busy and done decode directly from the state register, so reset
    // clears them without waiting for a clock edge.
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
//
// Directed testbench for alu_exec_unit with the default WIDTH of 16. Each
// step drives one command and compares the latency, busy behaviour, result
// and flags against hand-computed values.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  alu_cnt;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [15:0] result_hi;
    logic        zero;
    logic        carry;
    logic        ovf;
    logic        illegal;

    int assertCount = 0;
    int failCount   = 0;

    alu_exec_unit #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .alu_cnt   (alu_cnt),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .carry     (carry),
        .ovf       (ovf),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case something stalls the main sequence.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to 1 ns after the next rising edge. Inputs are driven and
    // outputs are sampled at this point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input int lat, input int expLat,
                            input logic [15:0] expRes, input logic [15:0] expHi,
                            input logic expZero, input logic expCarry,
                            input logic expOvf, input logic expIll);
        checkOutput($sformatf("%s.latency", tag), 32'(lat), 32'(expLat));
        checkOutput($sformatf("%s.result", tag), {16'h0, result}, {16'h0, expRes});
        checkOutput($sformatf("%s.result_hi", tag), {16'h0, result_hi}, {16'h0, expHi});
        checkOutput($sformatf("%s.zero", tag), {31'h0, zero}, {31'h0, expZero});
        checkOutput($sformatf("%s.carry", tag), {31'h0, carry}, {31'h0, expCarry});
        checkOutput($sformatf("%s.ovf", tag), {31'h0, ovf}, {31'h0, expOvf});
        checkOutput($sformatf("%s.illegal", tag), {31'h0, illegal}, {31'h0, expIll});
    endtask

    // Issue one command and wait, within a bounded number of cycles, for done.
    // Once the command is accepted, the inputs are scrambled to show that the
    // operands were latched. With poke set, start is toggled while the unit is
    // busy and is held high through the DONE cycle. Both must be ignored.
    task automatic applyStimulus(input string tag, input logic [3:0] op,
                                 input logic [15:0] av, input logic [15:0] bv,
                                 input bit poke, output int lat);
        int busyCnt;
        busyCnt = 0;
        alu_cnt = op;
        a       = av;
        b       = bv;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        alu_cnt = 4'b1111;
        a       = ~av;
        b       = ~bv;
        lat     = 1;
        if (busy === 1'b1) busyCnt++;
        while (done !== 1'b1 && lat < 40) begin
            if (poke) begin
                start   = lat[0];
                alu_cnt = 4'b0100;
            end
            tick();
            lat++;
            if (busy === 1'b1) busyCnt++;
        end
        checkOutput($sformatf("%s.busy_cycles", tag), 32'(busyCnt), 32'(lat));
        start = poke;
        tick();
        start = 1'b0;
        checkOutput($sformatf("%s.idle_busy", tag), {31'h0, busy}, 32'h0);
        checkOutput($sformatf("%s.idle_done", tag), {31'h0, done}, 32'h0);
    endtask

    initial begin
        int lat;
        int doneSeen;
        rst_n   = 1'b0;
        start   = 1'b0;
        alu_cnt = 4'b0000;
        a       = 16'h0000;
        b       = 16'h0000;

        // Reset state, checked before any clock edge.
        #2;
        checkOutput("rst.busy", {31'h0, busy}, 32'h0);
        checkOutput("rst.done", {31'h0, done}, 32'h0);
        checkOutput("rst.result", {16'h0, result}, 32'h0);
        checkOutput("rst.result_hi", {16'h0, result_hi}, 32'h0);
        checkOutput("rst.zero", {31'h0, zero}, 32'h0);
        checkOutput("rst.carry", {31'h0, carry}, 32'h0);
        checkOutput("rst.ovf", {31'h0, ovf}, 32'h0);
        checkOutput("rst.illegal", {31'h0, illegal}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single-cycle operations.
        applyStimulus("add_ovf", 4'b0100, 16'h7FFF, 16'h0001, 1'b0, lat);
        checkAll("add_ovf", lat, 1, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("sub_borrow", 4'b1100, 16'h0003, 16'h0005, 1'b0, lat);
        checkAll("sub_borrow", lat, 1, 16'hFFFE, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus("and", 4'b0000, 16'hF0F0, 16'hFF00, 1'b0, lat);
        checkAll("and", lat, 1, 16'hF000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("or", 4'b0010, 16'hF0F0, 16'h0F0F, 1'b0, lat);
        checkAll("or", lat, 1, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("xor", 4'b0011, 16'hAAAA, 16'hAAAA, 1'b0, lat);
        checkAll("xor", lat, 1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("add_carry", 4'b0100, 16'hFFFF, 16'h0001, 1'b0, lat);
        checkAll("add_carry", lat, 1, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus("sub_ovf", 4'b1100, 16'h8000, 16'h0001, 1'b0, lat);
        checkAll("sub_ovf", lat, 1, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);

        // Shifts: latency is the shift amount plus one, or 1 for a zero shift.
        applyStimulus("sll4", 4'b0001, 16'h0001, 16'h0004, 1'b0, lat);
        checkAll("sll4", lat, 5, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("srl15", 4'b0110, 16'h8000, 16'h000F, 1'b0, lat);
        checkAll("srl15", lat, 16, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("srl3", 4'b0110, 16'h00F0, 16'h0003, 1'b0, lat);
        checkAll("srl3", lat, 4, 16'h001E, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("sll0", 4'b0001, 16'h1234, 16'h0010, 1'b0, lat);
        checkAll("sll0", lat, 1, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Multiply: 17-cycle latency, full 32-bit product.
        applyStimulus("mult_max", 4'b0111, 16'hFFFF, 16'hFFFF, 1'b1, lat);
        checkAll("mult_max", lat, 17, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("mult_hi", 4'b0111, 16'h8000, 16'h0002, 1'b0, lat);
        checkAll("mult_hi", lat, 17, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("mult_small", 4'b0111, 16'h1234, 16'h0005, 1'b0, lat);
        checkAll("mult_small", lat, 17, 16'h5B04, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Illegal opcode.
        applyStimulus("illegal", 4'b1111, 16'h1234, 16'h5678, 1'b0, lat);
        checkAll("illegal", lat, 1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);

        // Reset in the 8th MULT cycle clears outputs immediately and aborts.
        alu_cnt = 4'b0111;
        a       = 16'h0003;
        b       = 16'h0005;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        repeat (7) tick();
        checkOutput("mid_mult.busy", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst.busy", {31'h0, busy}, 32'h0);
        checkOutput("mid_rst.done", {31'h0, done}, 32'h0);
        checkOutput("mid_rst.zero", {31'h0, zero}, 32'h0);
        checkOutput("mid_rst.illegal", {31'h0, illegal}, 32'h0);
        checkOutput("mid_rst.result", {16'h0, result}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        doneSeen = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (done !== 1'b0) doneSeen++;
        end
        checkOutput("post_rst.no_done", 32'(doneSeen), 32'h0);
        applyStimulus("post_rst_and", 4'b0000, 16'h00F0, 16'h0F0F, 1'b0, lat);
        checkAll("post_rst_and", lat, 1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits; shift amount is b[3:0].
REQ-002 clk  input  1  rising-edge clock, sole clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  command strobe; sampled only in IDLE.
REQ-005 alu_cnt  input  4  operation code from ALU control.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 busy  output  1  high from the cycle after start is accepted through the done cycle.
REQ-009 done  output  1  one-cycle pulse; result and flags valid.
REQ-010 result  output  WIDTH  result, or low half of product.
REQ-011 result_hi  output  WIDTH  high half of product; 0 for other ops.
REQ-012 zero  output  1  result (or full product for mult) equals 0.
REQ-013 carry  output  1  add carry-out / sub borrow; 0 otherwise.
REQ-014 ovf  output  1  signed overflow for add/sub; 0 otherwise.
REQ-015 illegal  output  1  alu_cnt not in the decoded set.

Function
REQ-016 Codes SHALL be: 0000 and, 0010 or, 0011 xor, 0100 add, 1100 sub (a-b), 0001 sll, 0110 srl (logical), 0111 mult (unsigned); all others illegal.
REQ-017 FSM states SHALL be IDLE, SHIFT, MULT, DONE; only IDLE accepts start.
REQ-018 On accepted start, alu_cnt, a and b SHALL be latched; later input changes SHALL NOT affect the operation.
REQ-019 and/or/xor/add/sub/illegal: IDLE->DONE; done SHALL assert in the cycle after the accepting edge (latency 1).
REQ-020 sll/srl with shamt=0: IDLE->DONE, result=a, latency 1.
REQ-021 sll/srl with shamt=n>0: SHIFT for n cycles, shifting one bit per cycle with zero fill, then DONE; latency n+1.
REQ-022 mult: MULT for exactly WIDTH cycles of shift-add, then DONE; latency WIDTH+1; {result_hi,result} = a*b, full 2*WIDTH product.
REQ-023 add: result = (a+b) mod 2^WIDTH; carry = bit WIDTH of sum; ovf = operand signs equal and result sign differs.
REQ-024 sub: result = (a-b) mod 2^WIDTH; carry = 1 iff a<b unsigned; ovf = operand signs differ and result sign differs from a.
REQ-025 illegal code: result=0, result_hi=0, zero=1, illegal=1, carry=ovf=0.
REQ-026 DONE SHALL last exactly one cycle then go to IDLE; start during DONE SHALL be ignored.
REQ-027 result, result_hi and flags SHALL update only at the edge entering DONE and hold until the next DONE entry.
REQ-028 start while busy SHALL be ignored with no effect on the operation in progress.
REQ-029 busy SHALL be low in IDLE and high in SHIFT, MULT and DONE.

Reset
REQ-030 rst_n low SHALL immediately (no clock) force IDLE and drive busy, done, result, result_hi, carry, ovf, illegal to 0 and zero to 0.
REQ-031 Reset asserted mid-SHIFT or mid-MULT SHALL abort the operation with no done pulse; first start after release SHALL behave as from power-up.

Verification
REQ-032 add: a=0x7FFF, b=0x0001, start 1 cycle -> next cycle done=1, result=0x8000, ovf=1, carry=0, zero=0.
REQ-033 sub: a=0x0003, b=0x0005 -> latency 1, result=0xFFFE, carry=1, ovf=0.
REQ-034 sll: a=0x0001, b=0x0004 -> busy 5 cycles, done on cycle 5, result=0x0010; srl a=0x8000, b=0x000F -> result=0x0001, latency 16.
REQ-035 mult: a=0xFFFF, b=0xFFFF -> done exactly 17 cycles after start, result_hi=0xFFFE, result=0x0001; start pulses during busy ignored.
REQ-036 illegal: alu_cnt=1111 -> latency 1, illegal=1, result=0, zero=1.
REQ-037 reset mid-mult: rst_n low at cycle 8 of MULT -> busy=0 and done=0 immediately, no later done pulse; new and a=0x00F0, b=0x0F0F -> result=0x0000, zero=1.
